// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request/response packet channel.
// Responses are routed back in order through an owner FIFO.
module mem_req_arbiter #(
    parameter int PKT_W     = 64,
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*PKT_W-1:0]     req_pkt_i,
    output logic [N_REQ-1:0]           req_ack_o,
    output logic [N_REQ-1:0]           resp_valid_o,
    output logic [PKT_W-1:0]           resp_pkt_o,
    output logic                       mem_req_valid_o,
    output logic [PKT_W-1:0]           mem_req_pkt_o,
    input  logic                       mem_req_ack_i,
    input  logic                       mem_resp_valid_i,
    input  logic [PKT_W-1:0]           mem_resp_pkt_i,
    output logic [$clog2(MAX_OUTST):0] outst_o,
    output logic                       err_o
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(MAX_OUTST) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_nxt;
    logic [IDW-1:0] lock_id;
    logic [IDW-1:0] lock_id_nxt;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] head;
    logic [IDW-1:0] fifo [MAX_OUTST];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           err;
    logic           issue;
    logic           push;
    logic           pop;
    logic           drop;

    // Locked owner wins; otherwise search upward from rr_ptr with wrap.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        owner = rr_ptr;
        if (state == LOCKED) begin
            owner = lock_id;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!found && req_valid_i[idx]) begin
                    owner = IDW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign head  = fifo[rptr];
    assign issue = reset && ((state == LOCKED) ||
                   ((|req_valid_i) && (count < CW'(MAX_OUTST))));
    assign push  = issue && mem_req_ack_i;
    assign pop   = reset && mem_resp_valid_i && (count != '0);
    assign drop  = mem_resp_valid_i && (count == '0);

    assign mem_req_valid_o = issue;
    assign mem_req_pkt_o   = req_pkt_i[int'(owner)*PKT_W +: PKT_W];
    assign req_ack_o       = push ? (N_REQ'(1) << owner) : '0;
    assign resp_valid_o    = pop ? (N_REQ'(1) << head) : '0;
    assign resp_pkt_o      = mem_resp_pkt_i;
    assign outst_o         = count;
    assign err_o           = err;

    always_comb begin
        state_nxt   = state;
        lock_id_nxt = lock_id;
        rr_nxt      = rr_ptr;
        unique case (1'b1)
            push: begin
                state_nxt = IDLE;
                rr_nxt    = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;
            end
            (issue && !mem_req_ack_i && state == IDLE): begin
                state_nxt   = LOCKED;
                lock_id_nxt = owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lock_id <= '0;
            rr_ptr  <= '0;
            err     <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
            rr_ptr  <= rr_nxt;
            if (drop) err <= 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Owner storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= owner;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: vector table, hand sequences and an
// ordered scoreboard of expected response owners and packets.
module tb_mem_req_arbiter;

    localparam int PKT_W = 64;
    localparam int N_REQ = 2;
    localparam int MAXO  = 4;
    localparam logic [63:0] K = 64'hF0F0_0000_0000_0F0F;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*PKT_W-1:0] req_pkt;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       resp_valid;
    logic [PKT_W-1:0]       resp_pkt;
    logic                   mem_req_valid;
    logic [PKT_W-1:0]       mem_req_pkt;
    logic                   mem_req_ack;
    logic                   mem_resp_valid;
    logic [PKT_W-1:0]       mem_resp_pkt;
    logic [2:0]             outst;
    logic                   err;

    logic [63:0] pk [2];
    assign req_pkt = {pk[1], pk[0]};

    typedef struct {
        logic [1:0]  own;
        logic [63:0] pkt;
    } sb_t;

    typedef struct {
        logic [1:0] rv;
        logic       ack;
        logic       rsp;
        logic       emv;
        logic [1:0] erack;
        logic [1:0] ersp;
        int         eout;
        logic       eerr;
    } vec_t;

    sb_t         sb [$];
    logic [63:0] brq [$];
    vec_t        tbl [18];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .PKT_W(PKT_W), .N_REQ(N_REQ), .MAX_OUTST(MAXO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid_i(req_valid),
        .req_pkt_i(req_pkt),
        .req_ack_o(req_ack),
        .resp_valid_o(resp_valid),
        .resp_pkt_o(resp_pkt),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_pkt_o(mem_req_pkt),
        .mem_req_ack_i(mem_req_ack),
        .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_pkt_i(mem_resp_pkt),
        .outst_o(outst),
        .err_o(err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, settle, compare, model bridge, advance.
    task automatic cyc(input logic [1:0] rv, input logic ack,
                       input logic rsp, input logic emv,
                       input logic [1:0] erack, input logic [1:0] ersp,
                       input int eout, input logic eerr, input int eown,
                       input string tag);
        sb_t e;
        int  idx;
        req_valid      = rv;
        mem_req_ack    = ack;
        mem_resp_valid = rsp;
        mem_resp_pkt   = 64'hDEAD;
        if (rsp && brq.size() > 0) mem_resp_pkt = brq.pop_front();
        #1;
        chk({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'(emv));
        chk({tag, " req_ack"}, 64'(req_ack), 64'(erack));
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'(ersp));
        chk({tag, " outst"}, 64'(outst), 64'(eout));
        chk({tag, " err"}, 64'(err), 64'(eerr));
        if (eown >= 0) chk({tag, " mem_req_pkt"}, mem_req_pkt, pk[eown]);
        idx = erack[1] ? 1 : 0;
        if (erack != 2'b00) sb.push_back('{erack, pk[idx] ^ K});
        if (mem_req_valid && mem_req_ack) brq.push_back(mem_req_pkt ^ K);
        if (resp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s resp_unexpected actual=%b required=00",
                         tag, resp_valid);
            end else begin
                e = sb.pop_front();
                chk({tag, " resp_owner"}, 64'(resp_valid), 64'(e.own));
                chk({tag, " resp_pkt"}, resp_pkt, e.pkt);
            end
        end
        @(posedge clk);
        #1;
        if (erack != 2'b00) pk[idx] = pk[idx] + 64'h100;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        req_valid      = '0;
        mem_req_ack    = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_pkt   = '0;
        sb.delete();
        brq.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushes;
        int pops;
        pk[0] = 64'h0000_0000_0000_1000;
        pk[1] = 64'h1111_0000_0000_2000;

        // Reset held with both requesters valid.
        reset          = 1'b0;
        mem_resp_pkt   = '0;
        sb.delete();
        brq.delete();
        #2;
        cyc(2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0, -1, "rst0");
        cyc(2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0, -1, "rst1");
        reset = 1'b1;
        cyc(2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0, 0, "rel0");
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0, 1'b0, 0, "rel1");
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1, 1'b0, 1, "rel2");
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2, 1'b0, -1, "rel3");

        // Back-to-back alternation, bridge answers two cycles later.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            pushes = (c < 8) ? c : 8;
            pops   = (c >= 2) ? c - 2 : 0;
            cyc((c < 8) ? 2'b11 : 2'b00, c < 8, c >= 2, c < 8,
                (c < 8) ? ((c % 2 == 1) ? 2'b10 : 2'b01) : 2'b00,
                (c >= 2) ? (((c - 2) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00,
                pushes - pops, 1'b0, (c < 8) ? c % 2 : -1, "alt");
        end

        // Requester 1 held without ack while requester 0 joins.
        do_reset();
        pk[0] = 64'h5A;
        pk[1] = 64'hA5;
        for (int c = 0; c < 5; c++)
            cyc((c < 2) ? 2'b10 : 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00,
                0, 1'b0, 1, "lock_wait");
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 0, 1'b0, 1, "lock_ack");
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1, 1'b0, 0, "lock_next");
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2, 1'b0, -1, "lock_end");

        // Fill, full stall, pop-then-issue, simultaneous push/pop, wrap, err.
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0, 1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 2, 1'b0};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 3, 1'b0};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4, 1'b0};
        tbl[5]  = '{2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 4, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 3, 1'b0};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4, 1'b0};
        tbl[8]  = '{2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 4, 1'b0};
        tbl[9]  = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 3, 1'b0};
        tbl[10] = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 3, 1'b0};
        tbl[11] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 2, 1'b0};
        tbl[12] = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2, 1'b0};
        tbl[13] = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1, 1'b0};
        tbl[14] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0};
        tbl[15] = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b0};
        tbl[16] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 0, 1'b1};
        tbl[17] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1, 1'b1};
        do_reset();
        for (int i = 0; i < 18; i++)
            cyc(tbl[i].rv, tbl[i].ack, tbl[i].rsp, tbl[i].emv,
                tbl[i].erack, tbl[i].ersp, tbl[i].eout, tbl[i].eerr, -1,
                $sformatf("tbl%0d", i));

        // Error flag is cleared only by reset.
        do_reset();
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0, -1, "err_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
